// File: rtl/eu_sched_pkg.sv
// Shared command layout, unit-class layout and decode helpers for eu_scheduler.
package eu_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP        = 2'b00,
    OP_START      = 2'b01,
    OP_WAIT_CLASS = 2'b10,
    OP_WAIT_ALL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    CLS_STMM = 2'd0,
    CLS_LN   = 2'd1,
    CLS_SILU = 2'd2,
    CLS_ATT  = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    ST_ACCEPT  = 2'd0,
    ST_STALL   = 2'd1,
    ST_BARRIER = 2'd2
  } state_e;

  typedef struct packed {
    op_e         op;
    cls_e        cls;
    logic [3:0]  idx;
    logic [23:0] arg;
  } cmd_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] flat;
  } unit_sel_t;

  localparam int DEF_NUM_STMM  = 4;
  localparam int DEF_NUM_LN    = 4;
  localparam int DEF_NUM_SILU  = 4;
  localparam int DEF_NUM_ATT   = 1;
  localparam int DEF_BASE_LN   = DEF_NUM_STMM;
  localparam int DEF_BASE_SILU = DEF_NUM_STMM + DEF_NUM_LN;
  localparam int DEF_BASE_ATT  = DEF_NUM_STMM + DEF_NUM_LN + DEF_NUM_SILU;

  function automatic int class_base(cls_e c, int n_stmm, int n_ln, int n_silu);
    case (c)
      CLS_STMM: return 0;
      CLS_LN:   return n_stmm;
      CLS_SILU: return n_stmm + n_ln;
      default:  return n_stmm + n_ln + n_silu;
    endcase
  endfunction

  function automatic int class_count(cls_e c, int n_stmm, int n_ln, int n_silu, int n_att);
    case (c)
      CLS_STMM: return n_stmm;
      CLS_LN:   return n_ln;
      CLS_SILU: return n_silu;
      default:  return n_att;
    endcase
  endfunction

  // Flat unit index for (class, index); valid is low when index is past the class size.
  function automatic unit_sel_t decode_unit(cls_e c, logic [3:0] idx,
                                            int n_stmm, int n_ln, int n_silu, int n_att);
    unit_sel_t s;
    int        i;
    i       = int'(idx);
    s.valid = (i < class_count(c, n_stmm, n_ln, n_silu, n_att));
    s.flat  = 8'(class_base(c, n_stmm, n_ln, n_silu) + i);
    return s;
  endfunction

endpackage

// File: rtl/eu_busy_tracker.sv
// Per-unit busy register with done bypass: exposes busy, free (idle or finishing
// this cycle) and a flag for a done pulse arriving at an idle, unstarted unit.
module eu_busy_tracker #(
  parameter int N = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_start,
  input  logic [N-1:0] i_done,
  output logic [N-1:0] o_busy,
  output logic [N-1:0] o_free,
  output logic         o_spurious
);

  logic [N-1:0] r_busy;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~i_done) | i_start;
  end

  assign o_busy     = r_busy;
  assign o_free     = ~r_busy | i_done;
  assign o_spurious = |(i_done & ~r_busy & ~i_start);

endmodule

// File: rtl/eu_scheduler.sv
// Command scheduler for the execution units: START dispatch, stall on busy target,
// class/all barriers. Define EU_SCHED_PERF_EN to build the performance counters.
module eu_scheduler
  import eu_sched_pkg::*;
#(
  parameter  int NUM_STMM  = DEF_NUM_STMM,
  parameter  int NUM_LN    = DEF_NUM_LN,
  parameter  int NUM_SILU  = DEF_NUM_SILU,
  parameter  int NUM_ATT   = DEF_NUM_ATT,
  localparam int NUM_UNITS = NUM_STMM + NUM_LN + NUM_SILU + NUM_ATT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [NUM_UNITS-1:0] unit_start,
  output logic [23:0]          unit_arg,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] busy_vec,
  output logic                 all_idle,
  output logic                 err,
  output logic [31:0]          perf_busy_cycles,
  output logic [15:0]          perf_cmd_count
);

  cmd_t                 w_cmd;
  unit_sel_t            w_sel;
  logic [NUM_UNITS-1:0] w_sel_oh, w_cls_mask, w_free, w_busy, w_start_issue, w_lat_mask;
  logic                 w_spurious, w_bad_idx, w_latch;
  state_e               r_state, w_state_nxt;
  logic [NUM_UNITS-1:0] r_mask, r_unit_start;
  logic [23:0]          r_hold_arg, r_unit_arg;
  logic                 r_err;

  function automatic logic [NUM_UNITS-1:0] class_mask(cls_e c);
    logic [NUM_UNITS-1:0] m;
    int                   lo, hi;
    lo = class_base(c, NUM_STMM, NUM_LN, NUM_SILU);
    hi = lo + class_count(c, NUM_STMM, NUM_LN, NUM_SILU, NUM_ATT);
    for (int u = 0; u < NUM_UNITS; u++) m[u] = (u >= lo) && (u < hi);
    return m;
  endfunction

  assign w_cmd      = cmd_t'(cmd);
  assign w_sel      = decode_unit(w_cmd.cls, w_cmd.idx, NUM_STMM, NUM_LN, NUM_SILU, NUM_ATT);
  assign w_sel_oh   = w_sel.valid ? (NUM_UNITS'(1) << w_sel.flat) : '0;
  assign w_cls_mask = class_mask(w_cmd.cls);

  eu_busy_tracker #(.N(NUM_UNITS)) u_busy (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start_issue),
    .i_done     (unit_done),
    .o_busy     (w_busy),
    .o_free     (w_free),
    .o_spurious (w_spurious)
  );

  // r_mask holds the stalled target (one-hot) or the set of units a barrier waits on.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_issue = '0;
    w_latch       = 1'b0;
    w_lat_mask    = '0;
    w_bad_idx     = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        if (cmd_valid) begin
          case (w_cmd.op)
            OP_START: begin
              if (!w_sel.valid) begin
                w_bad_idx = 1'b1;
              end else if (|(w_sel_oh & w_free)) begin
                w_start_issue = w_sel_oh;
              end else begin
                w_latch     = 1'b1;
                w_lat_mask  = w_sel_oh;
                w_state_nxt = ST_STALL;
              end
            end
            OP_WAIT_CLASS: begin
              if (!w_sel.valid) begin
                w_bad_idx = 1'b1;
              end else if (!(&(w_free | ~w_cls_mask))) begin
                w_latch     = 1'b1;
                w_lat_mask  = w_cls_mask;
                w_state_nxt = ST_BARRIER;
              end
            end
            OP_WAIT_ALL: begin
              if (!(&w_free)) begin
                w_latch     = 1'b1;
                w_lat_mask  = '1;
                w_state_nxt = ST_BARRIER;
              end
            end
            default: ;
          endcase
        end
      end
      ST_STALL: begin
        if (|(r_mask & w_free)) begin
          w_start_issue = r_mask;
          w_state_nxt   = ST_ACCEPT;
        end
      end
      ST_BARRIER: begin
        if (&(w_free | ~r_mask)) w_state_nxt = ST_ACCEPT;
      end
      default: w_state_nxt = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ACCEPT;
      r_mask       <= '0;
      r_hold_arg   <= '0;
      r_unit_start <= '0;
      r_unit_arg   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_unit_start <= w_start_issue;
      r_err        <= r_err | w_bad_idx | w_spurious;
      if (w_latch) begin
        r_mask     <= w_lat_mask;
        r_hold_arg <= w_cmd.arg;
      end
      if (|w_start_issue) r_unit_arg <= (r_state == ST_STALL) ? r_hold_arg : w_cmd.arg;
    end
  end

  assign cmd_ready  = (r_state == ST_ACCEPT);
  assign unit_start = r_unit_start;
  assign unit_arg   = r_unit_arg;
  assign busy_vec   = w_busy;
  assign all_idle   = ~|w_busy;
  assign err        = r_err;

`ifdef EU_SCHED_PERF_EN
  logic [31:0] r_perf_busy;
  logic [15:0] r_perf_cmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_busy <= '0;
      r_perf_cmd  <= '0;
    end else begin
      if ((|w_busy) && (r_perf_busy != 32'hFFFF_FFFF)) r_perf_busy <= r_perf_busy + 32'd1;
      if (cmd_valid && cmd_ready) r_perf_cmd <= r_perf_cmd + 16'd1;
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_cmd_count   = r_perf_cmd;
`else
  assign perf_busy_cycles = '0;
  assign perf_cmd_count   = '0;
`endif

endmodule

// File: tb/tb_eu_scheduler.sv
// Self-checking bench for eu_scheduler: directed scenarios plus randomized
// commands/dones, compared each cycle against a transaction-level model.
module tb_eu_scheduler;

  localparam int NU = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [NU-1:0] unit_start;
  logic [23:0]   unit_arg;
  logic [NU-1:0] unit_done;
  logic [NU-1:0] busy_vec;
  logic          all_idle;
  logic          err;
  logic [31:0]   perf_busy_cycles;
  logic [15:0]   perf_cmd_count;

  eu_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .cmd              (cmd),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .unit_start       (unit_start),
    .unit_arg         (unit_arg),
    .unit_done        (unit_done),
    .busy_vec         (busy_vec),
    .all_idle         (all_idle),
    .err              (err),
    .perf_busy_cycles (perf_busy_cycles),
    .perf_cmd_count   (perf_cmd_count)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: unit classes laid out as stmm[0..3], ln[4..7], silu[8..11], att[12].
  int          cls_base[4] = '{0, 4, 8, 12};
  int          cls_cnt[4]  = '{4, 4, 4, 1};
  bit          m_busy[NU];
  int          m_hold;      // 0 none, 1 waiting to start m_hold_u, 2 waiting on a group
  int          m_hold_u;
  int          m_hold_cls;  // -1 means all units
  logic [23:0] m_hold_arg;
  int          m_start;
  logic [23:0] m_arg;
  bit          m_err;
  longint      m_pbusy;
  int          m_pcmd;

  function automatic logic [31:0] enc(int op, int cls, int idx, logic [23:0] arg);
    logic [31:0] w;
    w = {op[1:0], cls[1:0], idx[3:0], arg};
    return w;
  endfunction

  function automatic bit unit_free(int u, logic [NU-1:0] d);
    return !m_busy[u] || d[u];
  endfunction

  function automatic bit group_free(int cls, logic [NU-1:0] d);
    for (int u = 0; u < NU; u++) begin
      if (cls < 0 || (u >= cls_base[cls] && u < cls_base[cls] + cls_cnt[cls]))
        if (!unit_free(u, d)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) m_busy[u] = 1'b0;
    m_hold = 0; m_hold_u = 0; m_hold_cls = 0; m_hold_arg = '0;
    m_start = -1; m_arg = '0; m_err = 1'b0; m_pbusy = 0; m_pcmd = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] c, input logic [NU-1:0] d);
    int          op, cls, idx, issue, tgt;
    logic [23:0] arg, iarg;
    bit          any;
    op = int'(c[31:30]); cls = int'(c[29:28]); idx = int'(c[27:24]); arg = c[23:0];
    issue = -1; iarg = '0; any = 1'b0;
    for (int u = 0; u < NU; u++) any |= m_busy[u];
    if (any) m_pbusy++;
    if (m_hold == 0) begin
      if (v) begin
        m_pcmd++;
        if (op == 1) begin
          if (idx >= cls_cnt[cls]) m_err = 1'b1;
          else begin
            tgt = cls_base[cls] + idx;
            if (unit_free(tgt, d)) begin issue = tgt; iarg = arg; end
            else begin m_hold = 1; m_hold_u = tgt; m_hold_arg = arg; end
          end
        end else if (op == 2) begin
          if (idx >= cls_cnt[cls]) m_err = 1'b1;
          else if (!group_free(cls, d)) begin m_hold = 2; m_hold_cls = cls; end
        end else if (op == 3) begin
          if (!group_free(-1, d)) begin m_hold = 2; m_hold_cls = -1; end
        end
      end
    end else if (m_hold == 1) begin
      if (unit_free(m_hold_u, d)) begin issue = m_hold_u; iarg = m_hold_arg; m_hold = 0; end
    end else begin
      if (group_free(m_hold_cls, d)) m_hold = 0;
    end
    for (int u = 0; u < NU; u++)
      if (d[u] && !m_busy[u] && u != issue) m_err = 1'b1;
    for (int u = 0; u < NU; u++)
      m_busy[u] = (m_busy[u] && !d[u]) || (u == issue);
    m_start = issue;
    if (issue >= 0) m_arg = iarg;
  endtask

  task automatic check_outputs();
    logic [NU-1:0] eb, es;
    eb = '0; es = '0;
    for (int u = 0; u < NU; u++) eb[u] = m_busy[u];
    if (m_start >= 0) es[m_start] = 1'b1;
    check("cmd_ready", cmd_ready, m_hold == 0);
    check("unit_start", unit_start, es);
    if (m_start >= 0) check("unit_arg", unit_arg, m_arg);
    check("busy_vec", busy_vec, eb);
    check("all_idle", all_idle, eb == '0);
    check("err", err, m_err);
`ifdef EU_SCHED_PERF_EN
    check("perf_busy", perf_busy_cycles, m_pbusy);
    check("perf_cmd", perf_cmd_count, m_pcmd & 16'hFFFF);
`else
    check("perf_busy", perf_busy_cycles, 0);
    check("perf_cmd", perf_cmd_count, 0);
`endif
  endtask

  // One clock cycle: compare outputs, apply inputs, advance model, cross the edge.
  task automatic step(input bit v, input logic [31:0] c, input logic [NU-1:0] d);
    check_outputs();
    cmd_valid = v; cmd = c; unit_done = d;
    model_step(v, c, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    logic [NU-1:0] d;
    for (int i = 0; i < 6; i++) begin
      d = '0;
      for (int u = 0; u < NU; u++) d[u] = m_busy[u];
      step(1'b0, '0, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; unit_done = '0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy_vec, 0);
    check("rst_idle", all_idle, 1);
    check("rst_err", err, 0);
    check("rst_start", unit_start, 0);
    check("rst_arg", unit_arg, 0);
    check("rst_perf_busy", perf_busy_cycles, 0);
    check("rst_perf_cmd", perf_cmd_count, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lows;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; unit_done = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // START stmm 2: pulse and argument one cycle after acceptance.
    step(1'b1, enc(1, 0, 2, 24'h00ABCD), '0);
    check("t1_pulse", unit_start, 13'h0004);
    check("t1_arg", unit_arg, 24'h00ABCD);
    check("t1_busy2", busy_vec[2], 1);
    drain();

    // Two STARTs to stmm 2; done 10 cycles after the first pulse.
    step(1'b1, enc(1, 0, 2, 24'h000111), '0);
    step(1'b1, enc(1, 0, 2, 24'h000222), '0);
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      if (!cmd_ready) lows++;
      step(1'b0, '0, (i == 9) ? 13'h0004 : 13'h0000);
    end
    check("t2_stall_cycles", lows, 10);
    check("t2_pulse", unit_start, 13'h0004);
    check("t2_arg", unit_arg, 24'h000222);
    check("t2_ready", cmd_ready, 1);
    drain();

    // silu 0, silu 3, att 0, then class and global barriers.
    step(1'b1, enc(1, 2, 0, 24'h00A000), '0);
    step(1'b1, enc(1, 2, 3, 24'h00A003), '0);
    step(1'b1, enc(1, 3, 0, 24'h00B000), '0);
    step(1'b1, enc(2, 2, 0, 24'h0), '0);
    step(1'b0, '0, '0);
    step(1'b0, '0, 13'h0100);
    check("t3_wait_hold", cmd_ready, 0);
    step(1'b0, '0, 13'h0800);
    check("t3_wait_done", cmd_ready, 1);
    check("t3_att_busy", busy_vec, 13'h1000);
    step(1'b1, enc(3, 0, 0, 24'h0), '0);
    step(1'b0, '0, '0);
    check("t3_all_hold", cmd_ready, 0);
    step(1'b0, '0, 13'h1000);
    check("t3_all_done", cmd_ready, 1);
    drain();

    // Invalid index, then a spurious done to idle stmm 0.
    step(1'b1, enc(1, 1, 5, 24'h0000FF), '0);
    check("t4_err", err, 1);
    check("t4_nostart", unit_start, 0);
    check("t4_ready", cmd_ready, 1);
    step(1'b0, '0, 13'h0001);
    check("t4_err_sticky", err, 1);
    check("t4_busy", busy_vec, 0);

    // Done and START on stmm 1 in the same cycle: no stall.
    step(1'b1, enc(1, 0, 1, 24'h000010), '0);
    step(1'b0, '0, '0);
    step(1'b0, '0, '0);
    step(1'b1, enc(1, 0, 1, 24'h000020), 13'h0002);
    check("t5_ready", cmd_ready, 1);
    check("t5_pulse", unit_start, 13'h0002);
    check("t5_busy1", busy_vec[1], 1);
    drain();

    // Reset in the middle of a barrier.
    step(1'b1, enc(1, 0, 0, 24'h000001), '0);
    step(1'b1, enc(3, 0, 0, 24'h0), '0);
    step(1'b0, '0, '0);
    check("t6_in_barrier", cmd_ready, 0);
    do_reset();

    // Three commands over seven busy cycles.
    step(1'b1, enc(1, 0, 0, 24'h000005), '0);
    step(1'b1, enc(0, 0, 0, 24'h0), '0);
    step(1'b1, enc(1, 0, 1, 24'h000006), '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0);
    step(1'b0, '0, 13'h0003);
`ifdef EU_SCHED_PERF_EN
    check("t7_perf_cmd", perf_cmd_count, 3);
    check("t7_perf_busy", perf_busy_cycles, 7);
`else
    check("t7_perf_cmd", perf_cmd_count, 0);
    check("t7_perf_busy", perf_busy_cycles, 0);
`endif

    // Randomized commands and completions.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit            v;
      int            r, op, cls, idx;
      logic [NU-1:0] d;
      v   = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 99));
      op  = (r < 20) ? 0 : (r < 75) ? 1 : (r < 92) ? 2 : 3;
      cls = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, cls_cnt[cls] - 1));
      d   = '0;
      for (int u = 0; u < NU; u++)
        if (m_busy[u] && $urandom_range(0, 3) == 0) d[u] = 1'b1;
      step(v, enc(op, cls, idx, 24'($urandom())), d);
    end
    drain();
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
